// File: rtl/mem_arbiter_if.sv
// Memory arbiter bus: I/D miss requests, write-through stores, main memory
// port and cache fill return path. "slave" is the arbiter's view, "master"
// is the view of the surrounding caches and memory.
interface mem_arbiter_if #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int WORD_IDX_W = $clog2(BLOCK_WORDS);

  // cache-side requests
  logic                  i_miss_req;
  logic [ADDR_W-1:0]     i_miss_addr;
  logic                  d_miss_req;
  logic [ADDR_W-1:0]     d_miss_addr;
  logic                  d_wr_req;
  logic [ADDR_W-1:0]     d_wr_addr;
  logic [DATA_W-1:0]     d_wr_data;
  logic                  d_wr_ack;
  // main memory port
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_data_in;
  logic [DATA_W-1:0]     mem_data_out;
  logic                  mem_data_valid;
  // fill return path
  logic [DATA_W-1:0]     fill_data;
  logic [WORD_IDX_W-1:0] fill_word;
  logic                  i_fill_we;
  logic                  d_fill_we;
  logic                  i_fill_done;
  logic                  d_fill_done;
  logic                  busy;

  modport slave (
    input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
    output d_wr_ack, mem_en, mem_wr, mem_addr, mem_data_in,
           fill_data, fill_word, i_fill_we, d_fill_we,
           i_fill_done, d_fill_done, busy
  );

  modport master (
    output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
    input  d_wr_ack, mem_en, mem_wr, mem_addr, mem_data_in,
           fill_data, fill_word, i_fill_we, d_fill_we,
           i_fill_done, d_fill_done, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one pipelined main memory between I-cache fills, D-cache
// fills and single-word write-through stores. Grants are non-preemptive;
// stores win, and simultaneous misses alternate by the side served last.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int OFF_W = $clog2(2 * BLOCK_WORDS);  // byte offset bits in a block
  localparam int CNT_W = $clog2(BLOCK_WORDS);      // word index bits

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] I_FILL  = 2'd1;
  localparam logic [1:0] D_FILL  = 2'd2;
  localparam logic [1:0] D_WRITE = 2'd3;

  localparam logic [CNT_W:0]   ISSUE_MAX = (CNT_W + 1)'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  logic [1:0]        state, state_next;
  logic [ADDR_W-1:0] base, base_next;
  logic [CNT_W:0]    issue_cnt, issue_next;  // one extra bit so it can saturate
  logic [CNT_W-1:0]  beat_cnt, beat_next;
  logic              last_d, last_d_next;

  logic fill_state, issuing, last_beat;

  // next-state, grant and counter logic
  always_comb begin
    state_next  = state;
    base_next   = base;
    issue_next  = issue_cnt;
    beat_next   = beat_cnt;
    last_d_next = last_d;
    case (state)
      IDLE: begin
        if (bus.d_wr_req) begin
          state_next = D_WRITE;
        end else if (bus.i_miss_req && (!bus.d_miss_req || last_d)) begin
          state_next = I_FILL;
          base_next  = {bus.i_miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end else if (bus.d_miss_req) begin
          state_next = D_FILL;
          base_next  = {bus.d_miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
      end
      D_WRITE: state_next = IDLE;
      I_FILL, D_FILL: begin
        if (issue_cnt < ISSUE_MAX) issue_next = issue_cnt + 1'b1;
        if (bus.mem_data_valid) begin
          if (beat_cnt == LAST_BEAT) begin
            state_next  = IDLE;
            issue_next  = '0;
            beat_next   = '0;
            last_d_next = (state == D_FILL);
          end else begin
            beat_next = beat_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // state registers; reset aborts any fill in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      last_d    <= 1'b0;
    end else begin
      state     <= state_next;
      base      <= base_next;
      issue_cnt <= issue_next;
      beat_cnt  <= beat_next;
      last_d    <= last_d_next;
    end
  end

  assign fill_state = (state == I_FILL) || (state == D_FILL);
  assign issuing    = fill_state && (issue_cnt < ISSUE_MAX);
  assign last_beat  = (beat_cnt == LAST_BEAT);

  // memory port: fill reads walk the block, stores pass straight through
  assign bus.mem_en      = issuing || (state == D_WRITE);
  assign bus.mem_wr      = (state == D_WRITE);
  assign bus.mem_addr    = (state == D_WRITE) ? bus.d_wr_addr :
                           issuing ? base + ADDR_W'({issue_cnt[CNT_W-1:0], 1'b0}) :
                           {ADDR_W{1'b0}};
  assign bus.mem_data_in = (state == D_WRITE) ? bus.d_wr_data : {DATA_W{1'b0}};
  assign bus.d_wr_ack    = (state == D_WRITE);
  assign bus.busy        = (state != IDLE);

  // fill return: returns outside a fill state are dropped
  assign bus.fill_data   = bus.mem_data_out;
  assign bus.fill_word   = beat_cnt;
  assign bus.i_fill_we   = (state == I_FILL) && bus.mem_data_valid;
  assign bus.d_fill_we   = (state == D_FILL) && bus.mem_data_valid;
  assign bus.i_fill_done = bus.i_fill_we && last_beat;
  assign bus.d_fill_done = bus.d_fill_we && last_beat;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory ops and
// fill beats; a negedge monitor pops and compares them, including timing.
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; bit first; bit gap; } mem_exp_t;
  typedef struct { bit side_d; logic [2:0] word; logic [15:0] data; bit done; } fill_exp_t;

  mem_exp_t  exp_mem[$];
  fill_exp_t exp_fill[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_end = -100;
  int first_cyc = 0;
  int i_beats = 0;
  int d_beats = 0;
  logic inj_valid = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", nm, act, cyc);
    end
  endtask

  task automatic push_fill(input bit side_d, input logic [15:0] addr, input bit gap);
    logic [15:0] b;
    b = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      exp_mem.push_back('{wr: 1'b0, addr: b + 16'(2 * k), data: 16'h0, first: (k == 0), gap: (gap && k == 0)});
      exp_fill.push_back('{side_d: side_d, word: 3'(k), data: mem_word(b + 16'(2 * k)), done: (k == 7)});
    end
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [15:0] data, input bit gap);
    exp_mem.push_back('{wr: 1'b1, addr: addr, data: data, first: 1'b0, gap: gap});
  endtask

  // which: 0 = i_fill_done, 1 = d_fill_done, 2 = d_wr_ack; drops the matching request
  task automatic wait_evt(input int which, input string nm);
    bit seen;
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      #1;
      seen = (which == 0) ? bus.i_fill_done : (which == 1) ? bus.d_fill_done : bus.d_wr_ack;
      n++;
    end
    chk({"wait_", nm}, 32'(seen), 32'd1);
    if (which == 0) bus.i_miss_req = 1'b0;
    else if (which == 1) bus.d_miss_req = 1'b0;
    else bus.d_wr_req = 1'b0;
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // pipelined memory model: read in cycle c returns in cycle c+LAT
  initial begin
    logic        vld [LAT];
    logic [15:0] adr [LAT];
    logic        rd_en;
    logic [15:0] rd_addr;
    for (int i = 0; i < LAT; i++) begin vld[i] = 1'b0; adr[i] = '0; end
    bus.mem_data_valid = 1'b0;
    bus.mem_data_out = '0;
    forever begin
      @(negedge clk);
      rd_en = bus.mem_en && !bus.mem_wr;
      rd_addr = bus.mem_addr;
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) begin vld[i] = vld[i-1]; adr[i] = adr[i-1]; end
      vld[0] = rd_en;
      adr[0] = rd_addr;
      bus.mem_data_valid = vld[LAT-1] | inj_valid;
      bus.mem_data_out = vld[LAT-1] ? mem_word(adr[LAT-1]) : 16'hDEAD;
    end
  end

  // monitor: pop and compare whenever the DUT issues or returns
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.mem_en) begin
        if (exp_mem.size() == 0) begin
          chk("spurious_mem_en", {bus.mem_wr, bus.mem_addr}, 32'h0);
        end else begin
          mem_exp_t e;
          e = exp_mem.pop_front();
          chk("mem_op", {bus.mem_wr, bus.d_wr_ack, bus.mem_addr}, {e.wr, e.wr, e.addr});
          if (e.wr) chk("mem_wdata", 32'(bus.mem_data_in), 32'(e.data));
          if (e.first) first_cyc = cyc;
          if (e.gap) chk("one_idle_gap", 32'(cyc - last_end), 32'd2);
          if (e.wr) last_end = cyc;
        end
      end else if (bus.d_wr_ack) begin
        chk("ack_without_write", 32'(bus.d_wr_ack), 32'd0);
      end
      if (bus.i_fill_we && bus.d_fill_we) chk("we_exclusive", 32'd2, 32'd1);
      if (bus.i_fill_we || bus.d_fill_we) begin
        if (bus.d_fill_we) d_beats++; else i_beats++;
        if (exp_fill.size() == 0) begin
          chk("spurious_fill_we", {bus.i_fill_we, bus.d_fill_we}, 32'h0);
        end else begin
          fill_exp_t f;
          f = exp_fill.pop_front();
          chk("fill_beat",
              {bus.d_fill_we, bus.fill_word, bus.fill_data, bus.i_fill_done | bus.d_fill_done},
              {f.side_d, f.word, f.data, f.done});
          if (f.done) begin
            chk("fill_occupancy", 32'(cyc - first_cyc), 32'(8 + LAT - 1));
            last_end = cyc;
          end
        end
      end else if (bus.i_fill_done || bus.d_fill_done) begin
        chk("done_without_we", {bus.i_fill_done, bus.d_fill_done}, 32'h0);
      end
    end
  end

  initial begin
    int ib0, db0, n;
    bus.i_miss_req = 0; bus.i_miss_addr = '0;
    bus.d_miss_req = 0; bus.d_miss_addr = '0;
    bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_data = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_mem", {bus.mem_en, bus.mem_wr, bus.mem_addr}, 32'h0);
    chk("reset_flags", {bus.d_wr_ack, bus.i_fill_we, bus.d_fill_we, bus.i_fill_done,
                        bus.d_fill_done, bus.busy, bus.fill_word}, 32'h0);
    chk("reset_wdata", 32'(bus.mem_data_in), 32'h0);
    #2 rst_n = 1'b1;

    // lone I miss at 0x0136
    @(negedge clk); #1;
    push_fill(1'b0, 16'h0136, 1'b0);
    bus.i_miss_addr = 16'h0136; bus.i_miss_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_in_fill", 32'(bus.busy), 32'd1);
    wait_evt(0, "i_done_0136");

    // valid pulse while IDLE must be ignored
    repeat (2) @(negedge clk);
    chk("idle_not_busy", 32'(bus.busy), 32'd0);
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    repeat (3) @(negedge clk);

    // simultaneous misses, last_d=0 -> D first, then I
    push_fill(1'b1, 16'h2000, 1'b0);
    push_fill(1'b0, 16'h0040, 1'b1);
    bus.i_miss_addr = 16'h0040; bus.d_miss_addr = 16'h2000;
    bus.i_miss_req = 1'b1; bus.d_miss_req = 1'b1;
    wait_evt(1, "d_done_2000");
    wait_evt(0, "i_done_0040");
    repeat (2) @(negedge clk);

    // store raised at beat 2 of an I fill waits for the fill
    push_fill(1'b0, 16'h0500, 1'b0);
    push_write(16'h1004, 16'hBEEF, 1'b1);
    ib0 = i_beats;
    bus.i_miss_addr = 16'h0500; bus.i_miss_req = 1'b1;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (i_beats < ib0 + 2 && n < 200);
    bus.d_wr_addr = 16'h1004; bus.d_wr_data = 16'hBEEF; bus.d_wr_req = 1'b1;
    wait_evt(0, "i_done_0500");
    wait_evt(2, "ack_1004");
    repeat (2) @(negedge clk);

    // store and D miss together -> store first, then D fill (last_d becomes 1)
    push_write(16'h2222, 16'h1234, 1'b0);
    push_fill(1'b1, 16'h0A1C, 1'b1);
    bus.d_wr_addr = 16'h2222; bus.d_wr_data = 16'h1234; bus.d_wr_req = 1'b1;
    bus.d_miss_addr = 16'h0A1C; bus.d_miss_req = 1'b1;
    wait_evt(2, "ack_2222");
    wait_evt(1, "d_done_0A10");
    repeat (2) @(negedge clk);

    // simultaneous misses with last_d=1 -> I first
    push_fill(1'b0, 16'h0040, 1'b0);
    push_fill(1'b1, 16'h2000, 1'b1);
    bus.i_miss_addr = 16'h0040; bus.d_miss_addr = 16'h2000;
    bus.i_miss_req = 1'b1; bus.d_miss_req = 1'b1;
    wait_evt(0, "i_done_0040b");
    wait_evt(1, "d_done_2000b");
    repeat (2) @(negedge clk);

    // top-of-space block, request dropped mid-fill
    push_fill(1'b0, 16'hFFF6, 1'b0);
    bus.i_miss_addr = 16'hFFF6; bus.i_miss_req = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_miss_req = 1'b0;
    wait_evt(0, "i_done_fff0");
    repeat (2) @(negedge clk);

    // reset after 3 returned beats of a D fill
    push_fill(1'b1, 16'h4000, 1'b0);
    db0 = d_beats;
    bus.d_miss_addr = 16'h4000; bus.d_miss_req = 1'b1;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (d_beats < db0 + 3 && n < 200);
    rst_n = 1'b0;
    bus.d_miss_req = 1'b0;
    exp_mem.delete();
    exp_fill.delete();
    #1;
    chk("abort_outs", {bus.mem_en, bus.busy, bus.d_fill_we, bus.d_fill_done, bus.fill_word}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);  // stale returns arrive while IDLE
    push_fill(1'b1, 16'h3008, 1'b0);
    bus.d_miss_addr = 16'h3008; bus.d_miss_req = 1'b1;
    wait_evt(1, "d_done_3000");

    repeat (6) @(negedge clk);
    chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
    chk("fill_queue_empty", 32'(exp_fill.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
